shift_add_responder: RTL and testbench



---
 rtl/shift_add_responder.sv | 146 ++++++++++++++
 tb/tb_shift_add_responder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/shift_add_responder.sv
// -----------------------------------------------------------------------------
// shift_add_responder
//
// Purpose:
//   Responder end of the start/ready operand handshake.  On an accepted start
//   it captures two unsigned WIDTH-bit operands and computes their 2*WIDTH-bit
//   product by iterative shift-and-add, one multiplier bit per clock.  The
//   result is presented on y (low half) and y_hi (high half) together with
//   ready.  The result outputs only ever change when an operation completes,
//   so an initiator may sample them on any cycle where ready is high.
//
// Optional feature (compile-time macro):
//   SHIFT_ADD_BUSY_ERR_EN  adds output busy_err, a registered one-cycle pulse
//                          following any clock edge at which start was high
//                          while an operation was already in flight.
//
// Ports:
//   clk       in   1      system clock, all state updates on the rising edge
//   rst       in   1      asynchronous, active-low reset
//   start     in   1      operation request, only honoured while idle
//   a         in   WIDTH  multiplicand, captured when start is accepted
//   b         in   WIDTH  multiplier, captured when start is accepted
//   y         out  WIDTH  product bits [WIDTH-1:0]
//   y_hi      out  WIDTH  product bits [2*WIDTH-1:WIDTH]
//   ready     out  1      idle, and y/y_hi hold the last completed result
//   busy_err  out  1      (SHIFT_ADD_BUSY_ERR_EN only) start seen while busy
//
// States:
//   IDLE | ready high; a start captures operands and launches an operation
//   CALC | one shift-and-add step per cycle, WIDTH steps in total
//   DONE | accumulator copied to y/y_hi, ready raised, back to IDLE
// -----------------------------------------------------------------------------
module shift_add_responder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_hi,
  output logic             ready
`ifdef SHIFT_ADD_BUSY_ERR_EN
  ,
  output logic             busy_err
`endif
);

  localparam int PW = 2 * WIDTH;
  // Counter must be able to hold the value WIDTH itself.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_y_hi;
  logic             r_ready;
`ifdef SHIFT_ADD_BUSY_ERR_EN
  logic             r_busy_err;
`endif

  // Partial-product step.  The accumulator is a full 2*WIDTH bits and the
  // multiplicand has been shifted at most WIDTH-1 places when its last bit is
  // added, so the sum can never exceed the product range.
  logic [PW-1:0] w_addend;
  logic [PW-1:0] w_acc_next;
  logic          w_last_step;

  assign w_addend    = r_mplier[0] ? r_mcand : '0;
  assign w_acc_next  = r_acc + w_addend;
  assign w_last_step = (r_cnt == CW'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_y        <= '0;
      r_y_hi     <= '0;
      r_ready    <= 1'b1;
`ifdef SHIFT_ADD_BUSY_ERR_EN
      r_busy_err <= 1'b0;
`endif
    end else begin
`ifdef SHIFT_ADD_BUSY_ERR_EN
      // Any start arriving outside IDLE is dropped; flag it for one cycle.
      r_busy_err <= start && (r_state != IDLE);
`endif
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= CW'(WIDTH);
            r_ready  <= 1'b0;
            r_state  <= CALC;
          end
        end

        CALC: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - CW'(1);
          if (w_last_step) begin
            r_state <= DONE;
          end
        end

        DONE: begin
          // Only place the visible result changes: never a partial sum.
          r_y     <= r_acc[WIDTH-1:0];
          r_y_hi  <= r_acc[PW-1:WIDTH];
          r_ready <= 1'b1;
          r_state <= IDLE;
        end

        default: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign y     = r_y;
  assign y_hi  = r_y_hi;
  assign ready = r_ready;
`ifdef SHIFT_ADD_BUSY_ERR_EN
  assign busy_err = r_busy_err;
`endif

endmodule

// File: tb/tb_shift_add_responder.sv
module tb_shift_add_responder;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] y;
  logic [7:0] y_hi;
  logic       ready;
`ifdef SHIFT_ADD_BUSY_ERR_EN
  logic       busy_err;
`endif

  shift_add_responder #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .y        (y),
    .y_hi     (y_hi),
    .ready    (ready)
`ifdef SHIFT_ADD_BUSY_ERR_EN
    ,
    .busy_err (busy_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] ey;
    logic [7:0] eyh;
    int         acc;
  } exp_t;

  exp_t q[$];
  logic prev_ready = 1'b1;
  int   busy_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every rising edge of ready is one completed result.
  always @(negedge clk) begin
    exp_t e;
`ifdef SHIFT_ADD_BUSY_ERR_EN
    if (rst && busy_err === 1'b1) busy_cnt++;
`endif
    if (!rst) begin
      prev_ready = 1'b1;
    end else begin
      if (ready === 1'b1 && prev_ready === 1'b0) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("y", {24'd0, y}, {24'd0, e.ey});
          chk("y_hi", {24'd0, y_hi}, {24'd0, e.eyh});
          chk("latency", 32'(cyc - e.acc), 32'd9);
        end
      end
      prev_ready = ready;
    end
  end

  task automatic wait_ready_negedge();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready === 1'b1) return;
    end
    chk("ready_timeout", 32'd0, 32'd1);
  endtask

  // Single-cycle start pulse; returns 1 ns after the accepting edge.
  task automatic issue(input logic [7:0] ta, input logic [7:0] tb_v,
                       input logic [7:0] ey, input logic [7:0] eyh);
    exp_t e;
    wait_ready_negedge();
    a = ta;
    b = tb_v;
    start = 1'b1;
    e.ey = ey; e.eyh = eyh; e.acc = cyc + 1;
    q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("ready_drop", {31'd0, ready}, 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (q.size() == 0 && ready === 1'b1) return;
    end
    chk("drain_timeout", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  logic [7:0] va [4] = '{8'd12, 8'd100, 8'hFF, 8'd7};
  logic [7:0] vb [4] = '{8'd13, 8'd100, 8'd2,  8'd0};
  logic [7:0] vy [4] = '{8'h9C, 8'h10, 8'hFE, 8'h00};
  logic [7:0] vh [4] = '{8'h00, 8'h27, 8'h01, 8'h00};

  initial begin
    int prev_acc;
    exp_t e;
    rst = 1'b0;
    start = 1'b0;
    a = 8'd0;
    b = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_y", {24'd0, y}, 32'd0);
    chk("rst_y_hi", {24'd0, y_hi}, 32'd0);
    @(posedge clk);
    #3 rst = 1'b1;

    // Basic, carry into high half, zero and identity.
    issue(8'd15,  8'd17,  8'hFF, 8'h00);
    drain();
    issue(8'd200, 8'd3,   8'h58, 8'h02);
    drain();
    issue(8'd255, 8'd255, 8'h01, 8'hFE);
    drain();
    issue(8'd0,   8'hAB,  8'h00, 8'h00);
    drain();
    issue(8'd1,   8'hAB,  8'hAB, 8'h00);
    drain();

    // Start during CALC must be ignored.
    busy_cnt = 0;
    issue(8'd2, 8'd3, 8'h06, 8'h00);
    @(negedge clk);
    @(negedge clk);
    a = 8'd9;
    b = 8'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain();
`ifdef SHIFT_ADD_BUSY_ERR_EN
    chk("busy_err_pulses", 32'(busy_cnt), 32'd1);
`endif

    // Reset mid-CALC discards the operation and clears the result.
    issue(8'd255, 8'd255, 8'h01, 8'hFE);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("midrst_ready", {31'd0, ready}, 32'd1);
    chk("midrst_y", {24'd0, y}, 32'd0);
    chk("midrst_y_hi", {24'd0, y_hi}, 32'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("postrst_ready", {31'd0, ready}, 32'd1);
    chk("postrst_y", {24'd0, y}, 32'd0);

    // Back-to-back with start held high; operands change at each ready.
    prev_acc = 0;
    for (int i = 0; i < 4; i++) begin
      wait_ready_negedge();
      a = va[i];
      b = vb[i];
      start = 1'b1;
      e.ey = vy[i]; e.eyh = vh[i]; e.acc = cyc + 1;
      q.push_back(e);
      if (i > 0) chk("b2b_spacing", 32'(e.acc - prev_acc), 32'd10);
      prev_acc = e.acc;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
